// File: rtl/bcd_seg_display_seq_pkg.sv
// rtl/bcd_seg_display_seq_pkg.sv - shared FSM encoding and active-low segment codes
package bcd_disp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_ENCODE = 2'd2
    } state_e;

    // Segment order is {a,b,c,d,e,f,g}, a 0 lights the segment
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;

endpackage

// File: rtl/bcd_seg_display_seq_if.sv
// rtl/bcd_seg_display_seq_if.sv - start/ready/done conversion bus and display outputs
interface bcd_seg_display_seq_if #(
    parameter int DATA_W = 8,
    parameter int DIGITS = 3
);
    logic                  start;
    logic [DATA_W-1:0]     data;
    logic                  sign_in;
    logic                  ready;
    logic                  done;
    logic [DIGITS*7-1:0]   seg;
    logic                  ovf;
    logic                  sign_n;

    modport master (
        output start, data, sign_in,
        input  ready, done, seg, ovf, sign_n
    );

    modport slave (
        input  start, data, sign_in,
        output ready, done, seg, ovf, sign_n
    );
endinterface

// File: rtl/bcd_seg_display_seq_enc.sv
// rtl/bcd_seg_display_seq_enc.sv - one BCD digit to active-low seven-segment pattern
module seg7_digit_enc
    import bcd_disp_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank_i,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank_i) begin
            case (digit)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/bcd_seg_display_seq.sv
// rtl/bcd_seg_display_seq.sv - double-dabble binary to seven-segment driver; BCD_LZB_EN enables leading-zero blanking
module bcd_seg_display_seq
    import bcd_disp_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DIGITS = 3,
    parameter int LIMIT  = 199
) (
    input  logic                 clk,
    input  logic                 rst,
    bcd_seg_display_seq_if.slave bus
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(DATA_W + 1);

    localparam logic [1:0] IDLE   = ST_IDLE;
    localparam logic [1:0] SHIFT  = ST_SHIFT;
    localparam logic [1:0] ENCODE = ST_ENCODE;

    // A limit at or above the largest representable input can never be exceeded
    localparam logic [63:0] MAXV   = (64'd1 << DATA_W) - 64'd1;
    localparam logic        LIM_ON = (64'(LIMIT) < MAXV);

    logic [1:0]             state;
    logic [CW-1:0]          cnt;
    logic [DATA_W-1:0]      bin;
    logic [DATA_W-1:0]      data_q;
    logic [BW-1:0]          bcd;
    logic [BW-1:0]          bcd_adj;
    logic [BW+DATA_W-1:0]   shifted;
    logic                   sign_q;
    logic                   over;
    logic [DIGITS-1:0]      blk;
    logic [DIGITS*7-1:0]    enc_seg;

    assign bus.ready = (state == IDLE);
    assign over      = LIM_ON && (data_q > DATA_W'(LIMIT));

    always_comb begin
        bcd_adj = bcd;
        for (int k = 0; k < DIGITS; k++) begin
            if (bcd[4*k +: 4] >= 4'd5)
                bcd_adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
        end
    end

    assign shifted = {bcd_adj, bin} << 1;

`ifdef BCD_LZB_EN
    logic lead;

    // Blank zeros from the top down until the first nonzero digit; units always shows
    always_comb begin
        blk  = '0;
        lead = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            lead   = lead & (bcd[4*k +: 4] == 4'd0);
            blk[k] = lead;
        end
    end
`else
    assign blk = '0;
`endif

    for (genvar k = 0; k < DIGITS; k++) begin : g_enc
        seg7_digit_enc u_enc (
            .digit   (bcd[4*k +: 4]),
            .blank_i (blk[k]),
            .seg     (enc_seg[7*k +: 7])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            bin        <= '0;
            data_q     <= '0;
            bcd        <= '0;
            sign_q     <= 1'b0;
            bus.done   <= 1'b0;
            bus.seg    <= '1;
            bus.ovf    <= 1'b0;
            bus.sign_n <= 1'b1;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        bin    <= bus.data;
                        data_q <= bus.data;
                        sign_q <= bus.sign_in;
                        bcd    <= '0;
                        cnt    <= CW'(DATA_W);
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    bcd <= shifted[BW+DATA_W-1:DATA_W];
                    bin <= shifted[DATA_W-1:0];
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1))
                        state <= ENCODE;
                end
                ENCODE: begin
                    bus.seg    <= over ? '1 : enc_seg;
                    bus.ovf    <= over;
                    bus.sign_n <= ~sign_q;
                    bus.done   <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
